// File: rtl/multiplicador_sequencial_ctrl_pkg.sv
// multiplicador_sequencial_ctrl_pkg: shared widths and FSM state encoding for the sequential multiplier
package multiplicador_sequencial_ctrl_pkg;
    localparam int OP_W   = 8;
    localparam int PROD_W = 16;
    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        SOMA   = 2'd1,
        FIM    = 2'd2
    } estado_t;
endpackage

// File: rtl/comparador8x8.sv
// comparador8x8: 8-bit equality comparator
//   A, B  : operands
//   Igual : high when A == B
module comparador8x8 (
    input  logic [7:0] A,
    input  logic [7:0] B,
    output logic       Igual
);
    assign Igual = (A == B);
endmodule

// File: rtl/multiplicador_sequencial_ctrl.sv
// multiplicador_sequencial_ctrl: 8x8 unsigned multiplier by repeated addition
//   clk, reset     : clock, synchronous active-high reset
//   inicio, A, B   : start request and operands (latched on acceptance in OCIOSO)
//   cancela        : abort, honoured only while accumulating
//   ocupado        : high while accumulating or finishing
//   pronto         : one-cycle done pulse
//   produto        : last completed product
//   overflow       : product does not fit 8 bits
module multiplicador_sequencial_ctrl
    import multiplicador_sequencial_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              inicio,
    input  logic              cancela,
    input  logic [OP_W-1:0]   A,
    input  logic [OP_W-1:0]   B,
    output logic              ocupado,
    output logic              pronto,
    output logic [PROD_W-1:0] produto,
    output logic              overflow
);
    estado_t             estado_q, estado_d;
    logic [OP_W-1:0]     a_q, a_d, b_q, b_d, cont_q, cont_d;
    logic [PROD_W-1:0]   acc_q, acc_d, produto_q, produto_d;
    logic                overflow_q, overflow_d, ocupado_q, ocupado_d, pronto_q, pronto_d;
    logic                igual;

    comparador8x8 u_cmp (
        .A     (cont_q),
        .B     (b_q),
        .Igual (igual)
    );

    always_comb begin
        estado_d   = OCIOSO;
        a_d        = a_q;
        b_d        = b_q;
        acc_d      = acc_q;
        cont_d     = cont_q;
        produto_d  = produto_q;
        overflow_d = overflow_q;
        case (estado_q)
            OCIOSO: if (inicio) begin
                a_d      = A;
                b_d      = B;
                acc_d    = '0;
                cont_d   = '0;
                estado_d = SOMA;
            end
            SOMA: if (cancela) begin
                estado_d = OCIOSO;
            end else if (igual) begin
                produto_d  = acc_q;
                overflow_d = |acc_q[PROD_W-1:OP_W];
                estado_d   = FIM;
            end else begin
                acc_d    = acc_q + {{(PROD_W-OP_W){1'b0}}, a_q};
                cont_d   = cont_q + 8'd1;
                estado_d = SOMA;
            end
            default: estado_d = OCIOSO;
        endcase
        // outputs are registered decodes of the next state so they line up with the state flop
        ocupado_d = (estado_d == SOMA) || (estado_d == FIM);
        pronto_d  = (estado_d == FIM);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q   <= OCIOSO;
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            cont_q     <= '0;
            produto_q  <= '0;
            overflow_q <= 1'b0;
            ocupado_q  <= 1'b0;
            pronto_q   <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            a_q        <= a_d;
            b_q        <= b_d;
            acc_q      <= acc_d;
            cont_q     <= cont_d;
            produto_q  <= produto_d;
            overflow_q <= overflow_d;
            ocupado_q  <= ocupado_d;
            pronto_q   <= pronto_d;
        end
    end

    assign ocupado  = ocupado_q;
    assign pronto   = pronto_q;
    assign produto  = produto_q;
    assign overflow = overflow_q;
endmodule

// File: tb/tb_multiplicador_sequencial_ctrl.sv
// tb_multiplicador_sequencial_ctrl: directed self-checking bench for the sequential multiplier
module tb_multiplicador_sequencial_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        inicio = 1'b0;
    logic        cancela = 1'b0;
    logic [7:0]  A = '0;
    logic [7:0]  B = '0;
    logic        ocupado, pronto, overflow;
    logic [15:0] produto;
    int          n_chk = 0;
    int          n_err = 0;

    multiplicador_sequencial_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .inicio   (inicio),
        .cancela  (cancela),
        .A        (A),
        .B        (B),
        .ocupado  (ocupado),
        .pronto   (pronto),
        .produto  (produto),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // starts a*b, optionally pulses inicio (A=B=9) in cycles ign1/ign2, returns the pronto cycle
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int ign1, input int ign2,
                          output int pr_cyc, output bit occ_ok);
        A = a;
        B = b;
        inicio = 1'b1;
        step();
        inicio = 1'b0;
        pr_cyc = -1;
        occ_ok = 1'b1;
        for (int c = 1; c <= 300; c++) begin
            inicio = (c == ign1) || (c == ign2);
            if (inicio) begin
                A = 8'd9;
                B = 8'd9;
            end
            occ_ok &= ocupado;
            if (pronto) begin
                pr_cyc = c;
                break;
            end
            step();
        end
        step();
        inicio = 1'b0;
    endtask

    initial begin
        int  pc;
        bit  ok;
        bit  saw;
        repeat (2) step();
        reset = 1'b0;
        chk("rst_produto", produto, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_pronto", pronto, 0);
        chk("rst_ocupado", ocupado, 0);

        run_op(8'd5, 8'd3, -1, -1, pc, ok);
        chk("basic_cycle", pc, 5);
        chk("basic_produto", produto, 15);
        chk("basic_overflow", overflow, 0);
        chk("basic_ocupado", ok, 1);
        chk("basic_idle_ocupado", ocupado, 0);
        chk("basic_idle_pronto", pronto, 0);

        run_op(8'd255, 8'd255, -1, -1, pc, ok);
        chk("worst_cycle", pc, 257);
        chk("worst_produto", produto, 16'hFE01);
        chk("worst_overflow", overflow, 1);

        run_op(8'd200, 8'd0, -1, -1, pc, ok);
        chk("zero_b_cycle", pc, 2);
        chk("zero_b_produto", produto, 0);
        chk("zero_b_overflow", overflow, 0);

        run_op(8'd0, 8'd7, -1, -1, pc, ok);
        chk("zero_a_cycle", pc, 9);
        chk("zero_a_produto", produto, 0);

        run_op(8'd4, 8'd6, 3, 8, pc, ok);
        chk("ign_cycle", pc, 8);
        chk("ign_produto", produto, 24);
        chk("ign_ocupado_a", ocupado, 0);
        step();
        chk("ign_ocupado_b", ocupado, 0);

        run_op(8'd5, 8'd3, -1, -1, pc, ok);
        chk("pre_cancel_produto", produto, 15);
        A = 8'd10;
        B = 8'd20;
        inicio = 1'b1;
        step();
        inicio = 1'b0;
        repeat (5) step();
        cancela = 1'b1;
        step();
        cancela = 1'b0;
        chk("cancel_ocupado", ocupado, 0);
        chk("cancel_pronto", pronto, 0);
        chk("cancel_produto", produto, 15);
        saw = 1'b0;
        for (int i = 0; i < 30; i++) begin
            saw |= pronto | ocupado;
            step();
        end
        chk("cancel_stays_idle", saw, 0);
        chk("cancel_produto_held", produto, 15);

        A = 8'd100;
        B = 8'd50;
        inicio = 1'b1;
        step();
        inicio = 1'b0;
        repeat (9) step();
        chk("mid_ocupado", ocupado, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mrst_produto", produto, 0);
        chk("mrst_overflow", overflow, 0);
        chk("mrst_pronto", pronto, 0);
        chk("mrst_ocupado", ocupado, 0);
        step();
        chk("mrst_idle", ocupado, 0);

        run_op(8'd3, 8'd3, -1, -1, pc, ok);
        chk("after_rst_cycle", pc, 5);
        chk("after_rst_produto", produto, 9);
        chk("after_rst_overflow", overflow, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
